connect4_turn_controller: RTL

Sequences play on the 4x4 Connect4 board. Accepts one column-select strobe per turn from the button front end and tracks per-column fill height. Emits a single-cycle board-cell write (position index = row*4 + col) tagged with the current player. Alternates turns, then checks the board for a win or a draw.

---
 rtl/connect4_turn_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/connect4_turn_controller.sv
// -----------------------------------------------------------------------------
// connect4_turn_controller
//
// Turn sequencer for a 4x4 Connect4 board. One column-select strobe per turn
// is accepted from the button front end. The controller tracks the fill
// height of each column and issues a single-cycle board-cell write tagged with
// the mover. It then checks the mover's pieces for four in a line or a full
// board, and either ends the game or hands the turn to the other player.
//
// Parameters:
//   FIRST_PLAYER     player who moves first after reset or new_game
//   NO_CELL          cell_pos value while no write is in progress
//
// Ports:
//   clk              system clock, all state on rising edge
//   reset            synchronous active-high clear of all state
//   new_game         synchronous restart, lower priority than reset
//   move_valid       move request strobe, only looked at while move_ready=1
//   selected_column  active-low one-hot column select (1110 = col0)
//   move_ready       high while waiting for a move
//   cell_we          one-cycle board write strobe
//   cell_pos         written cell index row*4+col, NO_CELL when idle
//   cell_player      owner of the written cell
//   current_player   player whose turn it is
//   move_reject      one-cycle pulse after an illegal move request
//   game_over        high once the game is won or drawn
//   winner           00 none, 01 player0, 10 player1, 11 draw
// -----------------------------------------------------------------------------
module connect4_turn_controller #(
    parameter logic       FIRST_PLAYER = 1'b0,
    parameter logic [4:0] NO_CELL      = 5'd31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] selected_column,
    output logic       move_ready,
    output logic       cell_we,
    output logic [4:0] cell_pos,
    output logic       cell_player,
    output logic       current_player,
    output logic       move_reject,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PLACE = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] WIN   = 3'd3;
    localparam logic [2:0] DRAW  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [3:0][2:0]  height_q, height_d;
    logic [15:0]      mask0_q, mask0_d;
    logic [15:0]      mask1_q, mask1_d;
    logic [4:0]       count_q, count_d;
    logic             player_q, player_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic             reject_q, reject_d;
    logic [1:0]       winner_q, winner_d;

    logic             col_ok;
    logic [1:0]       col_sel;
    logic             legal;
    logic [15:0]      cur_mask;

    // True when any of the ten winning lines is fully owned.
    function automatic logic has_line(input logic [15:0] m);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i*4 +: 4] == 4'hf) hit = 1'b1;
            if (m[i] && m[i+4] && m[i+8] && m[i+12]) hit = 1'b1;
        end
        if (m[0] && m[5] && m[10] && m[15]) hit = 1'b1;
        if (m[3] && m[6] && m[9]  && m[12]) hit = 1'b1;
        return hit;
    endfunction

    // Column decode; anything other than a single low bit is illegal.
    always_comb begin
        col_ok  = 1'b1;
        col_sel = 2'd0;
        case (selected_column)
            4'b1110: col_sel = 2'd0;
            4'b1101: col_sel = 2'd1;
            4'b1011: col_sel = 2'd2;
            4'b0111: col_sel = 2'd3;
            default: col_ok  = 1'b0;
        endcase
    end

    assign legal    = col_ok && (height_q[col_sel] < 3'd4);
    assign cur_mask = player_q ? mask1_q : mask0_q;

    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        mask0_d  = mask0_q;
        mask1_d  = mask1_q;
        count_d  = count_q;
        player_d = player_q;
        row_d    = row_q;
        col_d    = col_q;
        reject_d = 1'b0;
        winner_d = winner_q;

        case (state_q)
            IDLE: begin
                if (move_valid) begin
                    if (legal) begin
                        row_d   = height_q[col_sel][1:0];
                        col_d   = col_sel;
                        state_d = PLACE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            PLACE: begin
                if (player_q) mask1_d[{row_q, col_q}] = 1'b1;
                else          mask0_d[{row_q, col_q}] = 1'b1;
                // Saturate rather than wrap; legality already keeps it below 4.
                if (height_q[col_q] != 3'd4) height_d[col_q] = height_q[col_q] + 3'd1;
                count_d = count_q + 5'd1;
                state_d = CHECK;
            end
            CHECK: begin
                if (has_line(cur_mask)) begin
                    state_d  = WIN;
                    winner_d = player_q ? 2'b10 : 2'b01;
                end else if (count_q == 5'd16) begin
                    state_d  = DRAW;
                    winner_d = 2'b11;
                end else begin
                    player_d = ~player_q;
                    state_d  = IDLE;
                end
            end
            WIN, DRAW: state_d = state_q;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q  <= IDLE;
            height_q <= '0;
            mask0_q  <= '0;
            mask1_q  <= '0;
            count_q  <= '0;
            player_q <= FIRST_PLAYER;
            row_q    <= '0;
            col_q    <= '0;
            reject_q <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            mask0_q  <= mask0_d;
            mask1_q  <= mask1_d;
            count_q  <= count_d;
            player_q <= player_d;
            row_q    <= row_d;
            col_q    <= col_d;
            reject_q <= reject_d;
            winner_q <= winner_d;
        end
    end

    assign move_ready     = (state_q == IDLE);
    assign cell_we        = (state_q == PLACE);
    assign cell_pos       = cell_we ? {1'b0, row_q, col_q} : NO_CELL;
    assign cell_player    = player_q;
    assign current_player = player_q;
    assign move_reject    = reject_q;
    assign game_over      = (state_q == WIN) || (state_q == DRAW);
    assign winner         = winner_q;

endmodule
